// File: rtl/keypad_pkg.sv
// Shared key codes, debounce FSM states and command encodings for the keypad consumer.
// Pure declarations; no logic, no latency.
// Used by key_debounce and key_entry.
package keypad_pkg;

    localparam logic [4:0] KEY_A    = 5'd10;
    localparam logic [4:0] KEY_B    = 5'd11;
    localparam logic [4:0] KEY_C    = 5'd12;
    localparam logic [4:0] KEY_D    = 5'd13;
    localparam logic [4:0] KEY_HASH = 5'd14;
    localparam logic [4:0] KEY_STAR = 5'd15;
    localparam logic [4:0] KEY_NONE = 5'd31;

    localparam logic [1:0] CMD_A = 2'd0;
    localparam logic [1:0] CMD_B = 2'd1;
    localparam logic [1:0] CMD_C = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PRESS_DEB = 2'd1,
        ST_HELD      = 2'd2,
        ST_REL_DEB   = 2'd3
    } deb_state_e;

endpackage

// File: rtl/key_debounce.sv
// Debounces the scanner key/pressed pair into one key_evt pulse per physical press.
// key_evt fires DEBOUNCE_CYCLES cycles after the first stable raw-press cycle.
// No backpressure: events are single-cycle pulses and must be consumed immediately.
module key_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 270000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] key,
    input  logic       keypad_pressed,
    output logic       key_evt,
    output logic [3:0] evt_code
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    deb_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    cand_q, cand_d;
    logic          raw_press;

    // Codes 16-31 (including "none") read as released regardless of the flag.
    assign raw_press = keypad_pressed & ~key[4];
    assign evt_code  = cand_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        key_evt = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (raw_press) begin
                    cand_d  = key[3:0];
                    cnt_d   = '0;
                    state_d = ST_PRESS_DEB;
                end
            end
            ST_PRESS_DEB: begin
                if (!raw_press) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else if (key[3:0] != cand_q) begin
                    cand_d = key[3:0];
                    cnt_d  = '0;
                end else if (cnt_q == CNT_MAX) begin
                    key_evt = 1'b1;
                    state_d = ST_HELD;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_HELD: begin
                if (!raw_press) begin
                    cnt_d   = '0;
                    state_d = ST_REL_DEB;
                end
            end
            ST_REL_DEB: begin
                if (raw_press) begin
                    cnt_d   = '0;
                    state_d = ST_HELD;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            cand_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cand_q  <= cand_d;
        end
    end

endmodule

// File: rtl/key_entry.sv
// Keypad entry: BCD digit buffer with edit keys, committed code over valid/ready, A/B/C commands.
// Buffer/command/error outputs update on the edge that ends the debounced key event cycle.
// code_valid holds code/code_len stable until code_ready; keys arriving meanwhile are rejected.
module key_entry
    import keypad_pkg::*;
#(
    parameter int MAX_DIGITS      = 4,
    parameter int DEBOUNCE_CYCLES = 270000
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [4:0]                        key,
    input  logic                              keypad_pressed,
    output logic [4*MAX_DIGITS-1:0]           digits,
    output logic [$clog2(MAX_DIGITS+1)-1:0]   digit_count,
    output logic [4*MAX_DIGITS-1:0]           code,
    output logic [$clog2(MAX_DIGITS+1)-1:0]   code_len,
    output logic                              code_valid,
    input  logic                              code_ready,
    output logic [1:0]                        cmd,
    output logic                              cmd_valid,
    output logic                              entry_err
);

    localparam int DW = 4 * MAX_DIGITS;
    localparam int NW = $clog2(MAX_DIGITS + 1);

    logic          key_evt;
    logic [3:0]    evt_code;
    logic [4:0]    evt5;
    logic [3:0]    cmd_off;
    logic [DW-1:0] digits_q, digits_d, code_q, code_d;
    logic [NW-1:0] count_q, count_d, code_len_q, code_len_d;
    logic          code_vld_q, code_vld_d, cmd_vld_q, cmd_vld_d, err_q, err_d;
    logic [1:0]    cmd_q, cmd_d;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
        .clk            (clk),
        .rst_n          (rst_n),
        .key            (key),
        .keypad_pressed (keypad_pressed),
        .key_evt        (key_evt),
        .evt_code       (evt_code)
    );

    assign evt5    = {1'b0, evt_code};
    assign cmd_off = evt_code - 4'd10;

    always_comb begin
        digits_d   = digits_q;
        count_d    = count_q;
        code_d     = code_q;
        code_len_d = code_len_q;
        code_vld_d = code_vld_q;
        cmd_d      = cmd_q;
        cmd_vld_d  = 1'b0;
        err_d      = 1'b0;
        if (code_vld_q && code_ready) begin
            code_vld_d = 1'b0;
        end
        if (key_evt) begin
            if (evt5 == KEY_A || evt5 == KEY_B || evt5 == KEY_C) begin
                cmd_d     = cmd_off[1:0];
                cmd_vld_d = 1'b1;
            end else if (code_vld_q) begin
                if (evt5 == KEY_STAR) begin
                    digits_d = '0;
                    count_d  = '0;
                    // An acceptance in the same cycle wins; '*' then only clears the buffer.
                    if (!code_ready) begin
                        code_vld_d = 1'b0;
                        code_d     = '0;
                        code_len_d = '0;
                    end
                end else begin
                    err_d = 1'b1;
                end
            end else if (evt_code < 4'd10) begin
                if (count_q < NW'(MAX_DIGITS)) begin
                    digits_d = (digits_q << 4) | DW'(evt_code);
                    count_d  = count_q + NW'(1);
                end else begin
                    err_d = 1'b1;
                end
            end else if (evt5 == KEY_D) begin
                if (count_q != '0) begin
                    digits_d = digits_q >> 4;
                    count_d  = count_q - NW'(1);
                end else begin
                    err_d = 1'b1;
                end
            end else if (evt5 == KEY_STAR) begin
                digits_d = '0;
                count_d  = '0;
            end else begin
                if (count_q != '0) begin
                    code_d     = digits_q;
                    code_len_d = count_q;
                    code_vld_d = 1'b1;
                    digits_d   = '0;
                    count_d    = '0;
                end else begin
                    err_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digits_q   <= '0;
            count_q    <= '0;
            code_q     <= '0;
            code_len_q <= '0;
            code_vld_q <= 1'b0;
            cmd_q      <= '0;
            cmd_vld_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            digits_q   <= digits_d;
            count_q    <= count_d;
            code_q     <= code_d;
            code_len_q <= code_len_d;
            code_vld_q <= code_vld_d;
            cmd_q      <= cmd_d;
            cmd_vld_q  <= cmd_vld_d;
            err_q      <= err_d;
        end
    end

    assign digits      = digits_q;
    assign digit_count = count_q;
    assign code        = code_q;
    assign code_len    = code_len_q;
    assign code_valid  = code_vld_q;
    assign cmd         = cmd_q;
    assign cmd_valid   = cmd_vld_q;
    assign entry_err   = err_q;

endmodule

// File: tb/tb_key_entry.sv
// Directed bench for key_entry with DEBOUNCE_CYCLES=4, MAX_DIGITS=4.
module tb_key_entry;

    logic        clk;
    logic        rst_n;
    logic [4:0]  key;
    logic        keypad_pressed;
    logic [15:0] digits;
    logic [2:0]  digit_count;
    logic [15:0] code;
    logic [2:0]  code_len;
    logic        code_valid;
    logic        code_ready;
    logic [1:0]  cmd;
    logic        cmd_valid;
    logic        entry_err;

    int total = 0;
    int bad   = 0;
    int err_cnt = 0;
    int cmd_cnt = 0;
    int err_snap;
    int cmd_snap;

    key_entry #(.MAX_DIGITS(4), .DEBOUNCE_CYCLES(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .key            (key),
        .keypad_pressed (keypad_pressed),
        .digits         (digits),
        .digit_count    (digit_count),
        .code           (code),
        .code_len       (code_len),
        .code_valid     (code_valid),
        .code_ready     (code_ready),
        .cmd            (cmd),
        .cmd_valid      (cmd_valid),
        .entry_err      (entry_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters: a one-cycle pulse adds exactly one.
    always @(negedge clk) begin
        if (entry_err) err_cnt++;
        if (cmd_valid) cmd_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic press(input logic [4:0] k, input int hold, input int rel);
        key = k;
        keypad_pressed = 1'b1;
        repeat (hold) @(negedge clk);
        key = 5'd31;
        keypad_pressed = 1'b0;
        repeat (rel) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        key = 5'd31;
        keypad_pressed = 1'b0;
        code_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_digits", 32'(digits), 32'h0);
        chk("rst_count", 32'(digit_count), 32'h0);
        chk("rst_code", 32'(code), 32'h0);
        chk("rst_cvld", 32'(code_valid), 32'h0);
        chk("rst_cmdvld", 32'(cmd_valid), 32'h0);
        chk("rst_err", 32'(entry_err), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Clean presses 1,2,3; then a press too short to qualify.
        press(5'd1, 10, 10);
        press(5'd2, 10, 10);
        press(5'd3, 10, 10);
        chk("seq_digits", 32'(digits), 32'h0123);
        chk("seq_count", 32'(digit_count), 32'd3);
        press(5'd5, 3, 10);
        chk("short_digits", 32'(digits), 32'h0123);
        chk("short_count", 32'(digit_count), 32'd3);
        press(5'd15, 10, 10);
        chk("star_clear", 32'(digits), 32'h0);

        // Bouncy press then bouncy release.
        keypad_pressed = 1'b1;
        for (int i = 0; i < 20; i++) begin
            key = (i % 2 == 0) ? 5'd5 : 5'd31;
            @(negedge clk);
        end
        key = 5'd4;
        repeat (10) @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            keypad_pressed = (i % 2 == 1);
            @(negedge clk);
        end
        keypad_pressed = 1'b0;
        key = 5'd31;
        repeat (10) @(negedge clk);
        chk("bounce_digits", 32'(digits), 32'h0004);
        chk("bounce_count", 32'(digit_count), 32'd1);
        press(5'd15, 10, 10);

        // Full buffer, delete, clear.
        press(5'd1, 10, 10);
        press(5'd2, 10, 10);
        press(5'd3, 10, 10);
        press(5'd4, 10, 10);
        err_snap = err_cnt;
        press(5'd5, 10, 10);
        chk("full_err", 32'(err_cnt - err_snap), 32'd1);
        chk("full_digits", 32'(digits), 32'h1234);
        chk("full_count", 32'(digit_count), 32'd4);
        press(5'd13, 10, 10);
        chk("del_digits", 32'(digits), 32'h0123);
        chk("del_count", 32'(digit_count), 32'd3);
        press(5'd15, 10, 10);
        chk("clr_digits", 32'(digits), 32'h0);
        chk("clr_count", 32'(digit_count), 32'd0);

        // Commit 98 and hold it pending.
        press(5'd9, 10, 10);
        press(5'd8, 10, 10);
        press(5'd14, 10, 10);
        chk("commit_code", 32'(code), 32'h0098);
        chk("commit_len", 32'(code_len), 32'd2);
        chk("commit_vld", 32'(code_valid), 32'd1);
        chk("commit_digits", 32'(digits), 32'h0);
        chk("commit_count", 32'(digit_count), 32'd0);
        err_snap = err_cnt;
        press(5'd7, 10, 10);
        chk("pend_err", 32'(err_cnt - err_snap), 32'd1);
        chk("pend_code", 32'(code), 32'h0098);
        chk("pend_vld", 32'(code_valid), 32'd1);
        chk("pend_digits", 32'(digits), 32'h0);
        code_ready = 1'b1;
        @(negedge clk);
        chk("accept_vld", 32'(code_valid), 32'd0);
        code_ready = 1'b0;
        chk("accept_digits", 32'(digits), 32'h0);

        // Empty commit and a command key.
        err_snap = err_cnt;
        press(5'd14, 10, 10);
        chk("empty_hash_err", 32'(err_cnt - err_snap), 32'd1);
        chk("empty_hash_vld", 32'(code_valid), 32'd0);
        cmd_snap = cmd_cnt;
        press(5'd11, 10, 10);
        chk("cmd_pulses", 32'(cmd_cnt - cmd_snap), 32'd1);
        chk("cmd_val", 32'(cmd), 32'd1);

        // Exact action latency.
        key = 5'd6;
        keypad_pressed = 1'b1;
        repeat (4) @(negedge clk);
        chk("lat_early", 32'(digit_count), 32'd0);
        @(negedge clk);
        chk("lat_count", 32'(digit_count), 32'd1);
        chk("lat_digits", 32'(digits), 32'h0006);
        keypad_pressed = 1'b0;
        key = 5'd31;
        repeat (10) @(negedge clk);

        // Reset with a code pending and a press mid-debounce.
        press(5'd14, 10, 10);
        chk("pre_rst_vld", 32'(code_valid), 32'd1);
        key = 5'd2;
        keypad_pressed = 1'b1;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_vld", 32'(code_valid), 32'd0);
        chk("arst_code", 32'(code), 32'h0);
        chk("arst_len", 32'(code_len), 32'd0);
        chk("arst_digits", 32'(digits), 32'h0);
        chk("arst_cmd", 32'(cmd), 32'd0);
        keypad_pressed = 1'b0;
        key = 5'd31;
        @(negedge clk);
        rst_n = 1'b1;
        err_snap = err_cnt;
        cmd_snap = cmd_cnt;
        repeat (20) @(negedge clk);
        chk("post_rst_digits", 32'(digits), 32'h0);
        chk("post_rst_count", 32'(digit_count), 32'd0);
        chk("post_rst_err", 32'(err_cnt - err_snap), 32'd0);
        chk("post_rst_cmd", 32'(cmd_cnt - cmd_snap), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/key_entry.md
Name: key_entry

Overview:
- Consumer side of the keypad scanner interface: reads the scanner's 5-bit key code and pressed flag.
- Debounces the scanner outputs and emits exactly one event per physical press.
- Assembles decimal digits into a BCD entry buffer; '*' clears, 'D' deletes, '#' commits.
- Commits to game/control logic through a valid/ready handshake; A/B/C are forwarded as command pulses.

Parameters:
- MAX_DIGITS, 4: BCD digit capacity of the entry buffer (1..7).
- DEBOUNCE_CYCLES, 270000: consecutive clk cycles of stable press, or stable release, required (10 ms at 27 MHz).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- key  in  5  scanner key code: 0-9 digit, 10-13 A-D, 14 '#', 15 '*', 31 none.
- keypad_pressed  in  1  scanner pressed flag.
- digits  out  4*MAX_DIGITS  live BCD buffer; newest digit in bits [3:0].
- digit_count  out  $clog2(MAX_DIGITS+1)  number of digits currently entered.
- code  out  4*MAX_DIGITS  committed BCD value; stable while code_valid.
- code_len  out  $clog2(MAX_DIGITS+1)  committed digit count.
- code_valid  out  1  committed code pending.
- code_ready  in  1  consumer accepts code.
- cmd  out  2  0=A, 1=B, 2=C.
- cmd_valid  out  1  one-cycle command pulse.
- entry_err  out  1  one-cycle pulse on a rejected key.

Behaviour:
- Reset: all outputs 0; FSM in IDLE; debounce counter 0.
- Raw press: keypad_pressed=1 and key<=15. Codes 16-31 count as not pressed.
- FSM states: IDLE, PRESS_DEB, HELD, REL_DEB.
  - IDLE: on a raw press, latch key into cand, clear counter, go to PRESS_DEB.
  - PRESS_DEB: counter increments while a raw press with key==cand is seen.
    - Key differs: reload cand, clear counter.
    - Raw press drops: return to IDLE.
    - Counter reaches DEBOUNCE_CYCLES-1: action fires the same cycle, go to HELD.
  - HELD: first cycle with no raw press clears counter and goes to REL_DEB. A different valid key while in HELD is ignored (no event until release).
  - REL_DEB: counts not-pressed cycles. Any raw press clears counter and returns to HELD. Reaching DEBOUNCE_CYCLES-1 goes to IDLE.
- Action latency: exactly DEBOUNCE_CYCLES cycles after the first stable raw-press cycle.
- Actions while code_valid=0:
  - Digit 0-9:
    - If digit_count<MAX_DIGITS: digits <= {digits[4*MAX_DIGITS-5:0], d}; digit_count+1.
    - If full: buffer unchanged, entry_err pulse.
  - D: if count>0, shift digits right 4 (top nibble 0), count-1; if count=0, entry_err.
  - '*': digits<=0, count<=0.
  - '#':
    - If count>0: code<=digits, code_len<=count, code_valid<=1, digits/count cleared the same cycle.
    - If count=0: entry_err, no commit.
  - A/B/C: cmd<=key-10, cmd_valid=1 for one cycle.
- Actions while code_valid=1:
  - Digits, D and '#' are rejected with entry_err.
  - '*' cancels: code_valid<=0, code/code_len cleared.
  - A/B/C still pulse cmd_valid.
- Handshake: code_valid is held with code and code_len stable until a cycle with code_ready=1; code_valid falls the next edge.
  - Simultaneous code_ready and '*' action: ready takes precedence and '*' becomes a plain buffer clear.
  - code_ready while code_valid=0 has no effect.
- Entry is capped at MAX_DIGITS, so digit_count never wraps. The debounce counter saturates at DEBOUNCE_CYCLES-1 and is sized $clog2(DEBOUNCE_CYCLES).
- rst_n assertion mid-debounce or with code pending returns everything to reset values immediately; no event is emitted.

Decomposition:
- Shared package, keypad_pkg:
  - Key code constants: KEY_A=10, KEY_B=11, KEY_C=12, KEY_D=13, KEY_HASH=14, KEY_STAR=15, KEY_NONE=31.
  - FSM state enum.
  - cmd encoding constants.
- One natural sub-module, key_debounce: the 4-state FSM plus counter. Outputs key_evt (one-cycle pulse) and evt_code[3:0]. The key_entry top holds the buffer, commit register and handshake.

Test Plan (DEBOUNCE_CYCLES=4, MAX_DIGITS=4):
- Hold key=1 for 10 cycles, then key=31 for 10, repeated for 2,3 -> digits=0x0123, digit_count=3, one event per press. A 3-cycle press of key 5 produces nothing.
- key toggling 5/31 every cycle for 20 cycles, then a stable 4 -> only one digit 4 appended; a bouncy release does not re-trigger.
- Enter 1,2,3,4, then 5 -> entry_err pulse, digits=0x1234. Then D -> 0x0123, count 3. Then '*' -> 0, count 0.
- Enter 9,8 then '#' with code_ready=0 -> code=0x0098, code_len=2, code_valid held. Digit 7 -> entry_err. Raise code_ready -> code_valid=0 next cycle; digits empty.
- '#' on empty buffer -> entry_err, no code_valid. Press B -> cmd=1 with a single-cycle cmd_valid.
- Drop rst_n mid-press and with code_valid=1 -> all outputs 0 asynchronously. After release, no spurious event.
